// File: rtl/adder_subtractor.sv
// Registered N-bit ripple-carry adder/subtractor with carry, signed overflow,
// zero and negative flags; one-cycle latency, results held while idle.
module adder_subtractor #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         overflow,
  output logic         zero,
  output logic         neg
);

  logic [N-1:0] b_eff_c;
  logic [N-1:0] sum_c;
  logic [N:0]   carry_c;
  logic         overflow_c;

  // Subtraction is A + ~B + 1: invert B and inject sub as carry-in.
  assign b_eff_c    = b ^ {N{sub}};
  assign carry_c[0] = sub;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum_c[i]       = a[i] ^ b_eff_c[i] ^ carry_c[i];
    assign carry_c[i+1]   = (a[i] & b_eff_c[i]) | (carry_c[i] & (a[i] ^ b_eff_c[i]));
  end

  assign overflow_c = (a[N-1] == b_eff_c[N-1]) && (sum_c[N-1] != a[N-1]);

  // Result registers update only on valid input; out_valid tracks in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum      <= sum_c;
        cout     <= carry_c[N];
        overflow <= overflow_c;
        zero     <= (sum_c == '0);
        neg      <= sum_c[N-1];
      end
    end
  end

endmodule

// File: tb/tb_adder_subtractor.sv
// Directed and random checks of adder_subtractor (N=4) against an
// integer-arithmetic reference model through a one-deep scoreboard queue.
module tb_adder_subtractor;

  localparam int unsigned N = 4;

  typedef struct {
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         neg;
  } res_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         sub;
  logic         out_valid;
  logic [N-1:0] sum;
  logic         cout;
  logic         overflow;
  logic         zero;
  logic         neg;

  int   checks = 0;
  int   errors = 0;
  res_t sb[$];
  res_t held;
  res_t zres;

  adder_subtractor #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .sub(sub),
    .out_valid(out_valid), .sum(sum), .cout(cout), .overflow(overflow),
    .zero(zero), .neg(neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference built from plain integer arithmetic, independent of bit-level logic.
  function automatic res_t model(input int ia, input int ib, input logic isub);
    res_t r;
    int   full;
    int   sa;
    int   sbv;
    int   sres;
    full  = isub ? (ia - ib) : (ia + ib);
    r.sum = N'(full & ((1 << N) - 1));
    r.cout = isub ? (ia >= ib) : (full > ((1 << N) - 1));
    sa    = (ia >= (1 << (N - 1))) ? ia - (1 << N) : ia;
    sbv   = (ib >= (1 << (N - 1))) ? ib - (1 << N) : ib;
    sres  = isub ? (sa - sbv) : (sa + sbv);
    r.ovf = (sres > ((1 << (N - 1)) - 1)) || (sres < -(1 << (N - 1)));
    r.zero = (r.sum == '0);
    r.neg  = r.sum[N-1];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ev, input res_t e);
    chk({tag, ".out_valid"}, 8'(out_valid), 8'(ev));
    chk({tag, ".sum"},       8'(sum),       8'(e.sum));
    chk({tag, ".cout"},      8'(cout),      8'(e.cout));
    chk({tag, ".overflow"},  8'(overflow),  8'(e.ovf));
    chk({tag, ".zero"},      8'(zero),      8'(e.zero));
    chk({tag, ".neg"},       8'(neg),       8'(e.neg));
  endtask

  // One clock of stimulus: drive at negedge, compare just after the rising edge.
  task automatic step(input string tag, input logic v, input int ia, input int ib, input logic isub);
    @(negedge clk);
    in_valid = v;
    a        = N'(ia);
    b        = N'(ib);
    sub      = isub;
    if (v && rst_n) sb.push_back(model(ia, ib, isub));
    @(posedge clk);
    #1;
    if (!rst_n) begin
      check_all({tag, "_rst"}, 1'b0, zres);
    end else begin
      if (v) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL %s scoreboard_empty observed=0 expected=1", tag);
        end else begin
          held = sb.pop_front();
        end
      end
      check_all(tag, v, held);
    end
  endtask

  initial begin
    zres = '{sum: '0, cout: 1'b0, ovf: 1'b0, zero: 1'b0, neg: 1'b0};
    held = zres;
    rst_n = 1'b1;
    in_valid = 1'b1;
    a = 4'd7;
    b = 4'd3;
    sub = 1'b0;

    // Asynchronous reset with live inputs, before any clock edge.
    #1 rst_n = 1'b0;
    #1 check_all("rst_async", 1'b0, zres);
    step("rst_hold", 1'b1, 9, 9, 1'b0);

    // Release with in_valid low: no result on the release edge.
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1 check_all("rst_release", 1'b0, zres);

    step("add_3_5",   1'b1, 3, 5, 1'b0);
    step("add_15_1",  1'b1, 15, 1, 1'b0);
    step("idle_hold", 1'b0, 6, 2, 1'b1);
    step("idle_hold2",1'b0, 1, 14, 1'b0);
    step("sub_5_3",   1'b1, 5, 3, 1'b1);
    step("sub_3_5",   1'b1, 3, 5, 1'b1);
    step("sub_0_0",   1'b1, 0, 0, 1'b1);
    step("sub_8_1",   1'b1, 8, 1, 1'b1);
    step("add_7_1",   1'b1, 7, 1, 1'b0);
    step("add_15_15", 1'b1, 15, 15, 1'b0);

    for (int i = 0; i < 40; i++) begin
      step("rand", 1'b1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)));
      if (i == 20) begin
        // Mid-stream reset: outputs clear immediately, in-flight data dropped.
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_all("rst_mid", 1'b0, zres);
        sb.delete();
        held = zres;
        step("rst_mid_edge", 1'b1, 12, 3, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1 check_all("rst_mid_release", 1'b0, zres);
      end
    end

    step("tail_idle", 1'b0, 0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_subtractor.md
ADDER_SUBTRACTOR -- requirements
Module: adder_subtractor

Interface
REQ-001 Parameter N, default 4: operand and result width in bits; SHALL support any N >= 1.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operands and mode valid this cycle.
REQ-005 a  input  N  operand A, unsigned (two's-complement view for overflow flag).
REQ-006 b  input  N  operand B.
REQ-007 sub  input  1  mode: 0 = A+B, 1 = A-B.
REQ-008 out_valid  output  1  registered result valid.
REQ-009 sum  output  N  registered result, low N bits.
REQ-010 cout  output  1  registered carry-out; for sub=1, 1 = no borrow (A >= B unsigned).
REQ-011 overflow  output  1  registered signed two's-complement overflow.
REQ-012 zero  output  1  registered flag, 1 when sum == 0.
REQ-013 neg  output  1  registered flag, equal to sum[N-1].

Function
REQ-014 Effective operand b_eff SHALL be b when sub=0, bitwise ~b when sub=1; carry-in SHALL equal sub.
REQ-015 Arithmetic SHALL be an N-stage ripple-carry chain of full-adder cells; stage i carry-out feeds stage i+1 carry-in.
REQ-016 {cout,sum} SHALL equal the (N+1)-bit value {1'b0,a} + {1'b0,b_eff} + sub, truncated to N+1 bits.
REQ-017 overflow SHALL be 1 iff a[N-1] == b_eff[N-1] and sum[N-1] != a[N-1].
REQ-018 Latency SHALL be exactly 1 cycle: inputs sampled at rising edge with in_valid=1 appear on all outputs after that edge.
REQ-019 out_valid SHALL be the registered copy of in_valid.
REQ-020 When in_valid=0, sum, cout, overflow, zero, neg SHALL hold their previous values; out_valid SHALL go to 0.
REQ-021 Back-to-back in_valid=1 cycles SHALL produce one result per cycle with no bubbles.
REQ-022 Wrap-around: additions exceeding 2^N-1 SHALL wrap sum modulo 2^N with cout=1; subtraction with A < B SHALL yield sum = (A-B) mod 2^N with cout=0.
REQ-023 No X/Z propagation from unused paths; outputs SHALL be driven from registers only.

Reset
REQ-024 While rst_n=0, out_valid, sum, cout, overflow, zero, neg SHALL be 0 immediately, independent of clk.
REQ-025 Reset asserted mid-stream SHALL discard the in-flight result; first valid result after release SHALL come from the first in_valid=1 edge with rst_n=1.
REQ-026 Reset release SHALL take effect at the next rising clk edge; no result is produced on the release edge unless in_valid=1 at that edge.

Verification (N=4)
REQ-027 rst_n=0 with any inputs -> all outputs 0, out_valid=0, without a clock edge.
REQ-028 a=3, b=5, sub=0, in_valid=1 -> next cycle sum=8, cout=0, overflow=1, zero=0, neg=1, out_valid=1.
REQ-029 a=15, b=1, sub=0 -> sum=0, cout=1, overflow=0, zero=1; then in_valid=0 -> values held, out_valid=0.
REQ-030 a=5, b=3, sub=1 -> sum=2, cout=1, overflow=0; a=3, b=5, sub=1 -> sum=14, cout=0, overflow=0, neg=1.
REQ-031 a=0, b=0, sub=1 -> sum=0, cout=1, zero=1; a=8, b=1, sub=1 -> sum=7, cout=1, overflow=1.
REQ-032 32+ random back-to-back vectors, results checked one cycle later against REQ-016/017, plus rst_n pulse mid-stream -> outputs 0 and stream resumes correctly.
